sync_fifo: RTL and testbench

- Single-clock, parametrised FIFO for the next generation of our storage blocks: storage, pointers, occupancy count and status flags in one block.
- Adds full/empty and almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush, and a selectable standard or first-word-fall-through (FWFT) read mode.
- Used as the intra-domain buffer on either side of the CDC crossings.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/sync_fifo_mem.sv | 21 ++
 rtl/sync_fifo.sv | 113 +++++++++++
 tb/tb_sync_fifo.sv | 118 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, read-mode constants and parameter sanity helpers
package fifo_pkg;
  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction
  function automatic bit thresh_ok(input int depth, input int afull, input int aempty);
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: flop-array storage with one write port and a combinational read
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_wr_en,
  input  logic [addr_w(DEPTH)-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  input  logic [addr_w(DEPTH)-1:0]   i_rd_addr,
  output logic [DATA_WIDTH-1:0]      o_rd_data
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  // write port; contents deliberately unreset
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end
  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with status flags, sticky errors, flush and std/FWFT read
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = MODE_STD
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic                      i_clr_err,
  input  logic                      i_wr_en,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  input  logic                      i_rd_en,
  output logic [DATA_WIDTH-1:0]     o_rd_data,
  output logic                      o_rd_valid,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_almost_full,
  output logic                      o_almost_empty,
  output logic                      o_overflow,
  output logic                      o_underflow
);
  localparam int AW = addr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (!thresh_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
    $error("sync_fifo: almost-full/almost-empty threshold out of range");
  end
  if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo: FWFT must be 0 or 1");
  end

  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf, r_udf;
  logic                  w_full, w_empty, w_rd_acc, w_wr_acc, w_mem_we;
  logic [DATA_WIDTH-1:0] w_mem_rd;

  assign w_full   = r_count == CW'(DEPTH);
  assign w_empty  = r_count == '0;
  assign w_rd_acc = i_rd_en & !w_empty;
  assign w_wr_acc = i_wr_en & (!w_full | w_rd_acc);
  assign w_mem_we = i_rst_n & !i_flush & w_wr_acc;

  sync_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (w_mem_we),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_rd)
  );

  // pointers, occupancy and sticky errors; flush empties but keeps error history
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_wr_acc);
      r_rd_ptr <= r_rd_ptr + AW'(w_rd_acc);
      r_count  <= (w_wr_acc & !w_rd_acc) ? r_count + 1'b1 :
                  (w_rd_acc & !w_wr_acc) ? r_count - 1'b1 : r_count;
      r_ovf    <= (i_wr_en & !w_wr_acc) | (r_ovf & !i_clr_err);
      r_udf    <= (i_rd_en & !w_rd_acc) | (r_udf & !i_clr_err);
    end
  end

  if (FWFT == MODE_FWFT) begin : g_fwft
    assign o_rd_data  = w_mem_rd;
    assign o_rd_valid = !w_empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    // registered read: head word captured on each accepted pop, held otherwise
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else if (i_flush) begin
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= w_mem_rd;
      end
    end
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
  end

  assign o_count        = r_count;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = r_count >= CW'(AFULL_THRESH);
  assign o_almost_empty = r_count <= CW'(AEMPTY_THRESH);
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: vector-table bench for standard and FWFT sync_fifo instances
module tb_sync_fifo;
  logic       clk = 1'b0, rst_n = 1'b0, flush = 1'b0, clr = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] wd = 8'h00;
  logic [7:0] s_rd, f_rd;
  logic [4:0] s_cnt, f_cnt;
  logic       s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  int         pass = 0, total = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_clr_err(clr),
    .i_wr_en(wr), .i_wr_data(wd), .i_rd_en(rd),
    .o_rd_data(s_rd), .o_rd_valid(s_rv), .o_count(s_cnt), .o_full(s_full),
    .o_empty(s_empty), .o_almost_full(s_af), .o_almost_empty(s_ae),
    .o_overflow(s_ovf), .o_underflow(s_udf)
  );

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_clr_err(clr),
    .i_wr_en(wr), .i_wr_data(wd), .i_rd_en(rd),
    .o_rd_data(f_rd), .o_rd_valid(f_rv), .o_count(f_cnt), .o_full(f_full),
    .o_empty(f_empty), .o_almost_full(f_af), .o_almost_empty(f_ae),
    .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  typedef struct {
    string      n;
    bit         rst, wr, rd, fl, clr;
    logic [7:0] wd;
    int         cnt;
    bit         ovf, udf, rv;
    logic [7:0] rdat;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  function automatic vec_t mk(input string n, input bit rst_i, input bit wr_i, input bit rd_i,
                              input bit fl_i, input bit clr_i, input logic [7:0] wd_i,
                              input int cnt, input bit ovf, input bit udf, input bit rv,
                              input logic [7:0] rdat);
    vec_t v;
    v.n = n; v.rst = rst_i; v.wr = wr_i; v.rd = rd_i; v.fl = fl_i; v.clr = clr_i;
    v.wd = wd_i; v.cnt = cnt; v.ovf = ovf; v.udf = udf; v.rv = rv; v.rdat = rdat;
    return v;
  endfunction

  initial begin
    logic [11:0] exp_st, act_st;
    logic [4:0]  c5;
    vq.push_back(mk("reset", 1,0,0,0,0, 8'h00, 0, 0,0,0, 8'h00));
    for (int i = 0; i < 16; i++)
      vq.push_back(mk("wr_fill", 0,1,0,0,0, 8'(i), i+1, 0,0,0, 8'h00));
    vq.push_back(mk("ovf_wr", 0,1,0,0,0, 8'hAA, 16, 1,0,0, 8'h00));
    vq.push_back(mk("clr_ovf", 0,0,0,0,1, 8'h00, 16, 0,0,0, 8'h00));
    vq.push_back(mk("full_rw", 0,1,1,0,0, 8'h55, 16, 0,0,1, 8'h00));
    for (int i = 1; i < 16; i++)
      vq.push_back(mk("rd_drain", 0,0,1,0,0, 8'h00, 16-i, 0,0,1, 8'(i)));
    vq.push_back(mk("rd_55", 0,0,1,0,0, 8'h00, 0, 0,0,1, 8'h55));
    vq.push_back(mk("empty_rw", 0,1,1,0,0, 8'h33, 1, 0,1,0, 8'h55));
    vq.push_back(mk("rd_33", 0,0,1,0,0, 8'h00, 0, 0,1,1, 8'h33));
    vq.push_back(mk("clr_udf", 0,0,0,0,1, 8'h00, 0, 0,0,0, 8'h33));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk("wr5", 0,1,0,0,0, 8'(8'h10+i), i+1, 0,0,0, 8'h33));
    vq.push_back(mk("flush_wr", 0,1,0,1,0, 8'h99, 0, 0,0,0, 8'h33));
    vq.push_back(mk("rd_empty", 0,0,1,0,0, 8'h00, 0, 0,1,0, 8'h33));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk("wr3", 0,1,0,0,0, 8'(8'h20+i), i+1, 0,1,0, 8'h33));
    vq.push_back(mk("rd_20", 0,0,1,0,0, 8'h00, 2, 0,1,1, 8'h20));
    vq.push_back(mk("rst_mid", 1,1,0,0,0, 8'h44, 0, 0,0,0, 8'h00));
    vq.push_back(mk("rd_after_rst", 0,0,1,0,0, 8'h00, 0, 0,1,0, 8'h00));

    foreach (vq[k]) begin
      rst_n = !vq[k].rst; wr = vq[k].wr; rd = vq[k].rd; flush = vq[k].fl;
      clr = vq[k].clr; wd = vq[k].wd;
      @(posedge clk); #1;
      c5 = 5'(vq[k].cnt);
      exp_st = {c5, vq[k].cnt == 16, vq[k].cnt == 0, vq[k].cnt >= 14, vq[k].cnt <= 2,
                vq[k].ovf, vq[k].udf, vq[k].rv};
      act_st = {s_cnt, s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_rv};
      chk({vq[k].n, "_status"}, 32'(act_st), 32'(exp_st));
      chk({vq[k].n, "_rdata"}, 32'(s_rd), 32'(vq[k].rdat));
      chk({vq[k].n, "_fwft_valid"}, 32'(f_rv), 32'(vq[k].cnt != 0));
    end
    rst_n = 1'b1; wr = 1'b0; rd = 1'b0; flush = 1'b0; clr = 1'b0;

    // FWFT: word written into an empty FIFO shows up before any pop
    wr = 1'b1; wd = 8'h7E;
    @(posedge clk); #1;
    wr = 1'b0;
    chk("fwft_wr_valid", 32'(f_rv), 32'd1);
    chk("fwft_wr_data", 32'(f_rd), 32'h7E);
    chk("std_wr_valid", 32'(s_rv), 32'd0);
    @(posedge clk); #1;
    chk("fwft_hold_data", 32'(f_rd), 32'h7E);
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    chk("fwft_pop_valid", 32'(f_rv), 32'd0);
    chk("fwft_pop_count", 32'(f_cnt), 32'd0);
    chk("std_pop_valid", 32'(s_rv), 32'd1);
    chk("std_pop_data", 32'(s_rd), 32'h7E);
    @(posedge clk); #1;
    chk("std_idle_valid", 32'(s_rv), 32'd0);
    chk("std_idle_hold", 32'(s_rd), 32'h7E);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
